prog_seq: RTL and testbench
===========================

Name: prog_seq

Overview:
- Instruction sequencer placed directly upstream of the 8-bit processor core.
- Holds a small program memory loaded by the host, then issues one 15-bit word per issue slot onto the core's opcode[9:0] and data[4:0] inputs.
- Inserts NOP bubbles between instructions so each result has left the core's register/ALU/bus/demux pipeline before the next instruction issues.
- Stops on a HALT word or at end of memory.

Parameters:
- DEPTH, 16, number of program words.
- AW, 4, address width; DEPTH = 2**AW.
- GAP, 4, NOP cycles inserted after each issued instruction; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock, same clock as the processor core.
- rst  in  1  synchronous, active-high reset.
- ld_en  in  1  program-memory write strobe.
- ld_addr  in  AW  write address.
- ld_word  in  15  write data; [14:5] = opcode, [4:0] = data.
- start  in  1  single-cycle run request.
- stall  in  1  freezes sequencing; NOP is driven while high.
- opcode  out  10  to the core's opcode input.
- data  out  5  to the core's data input.
- pc  out  AW  address of the next word to issue.
- busy  out  1  high in the ISSUE and GAP states.
- done  out  1  high in the DONE state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- NOP encoding: 10'b0001_000_101, i.e. ADD, source 0, destination 5. The core's demux has no case for destination 5, so core registers are untouched.
- HALT encoding: opcode[9:6] = 4'b1111. This value is unused by the core and is never forwarded to it.
- Reset values:
  - state = IDLE, pc = 0, gap counter = 0.
  - opcode = NOP, data = 0, busy = 0, done = 0.
  - Program memory has no reset; its contents survive rst.
- All outputs are registered. Memory read is combinational from the register array, so the word at pc appears on opcode/data one cycle after being selected.
- State IDLE:
  - ld_en = 1 writes mem[ld_addr] = ld_word.
  - start = 1 sets pc = 0 and moves to ISSUE.
  - ld_en and start in the same cycle: the write happens and start is honoured. The first word read is the post-write value, because the read occurs in the following cycle.
- State ISSUE, per cycle:
  - stall = 1: output NOP; pc and state hold.
  - mem[pc] is HALT: output NOP, go to DONE, pc holds.
  - Otherwise: output mem[pc] and increment pc.
    - If pc was DEPTH-1, go to DONE; pc wraps to 0.
    - Else if GAP = 0, stay in ISSUE.
    - Else load the gap counter with GAP-1 and go to GAP.
- State GAP:
  - Output NOP each cycle.
  - Counter decrements only when stall = 0.
  - Counter = 0 with stall = 0 returns to ISSUE.
  - Exactly GAP NOP cycles appear between two issued instructions when stall stays low.
- State DONE:
  - done = 1, opcode = NOP.
  - Loads are accepted.
  - start = 1 restarts from pc = 0 and moves to ISSUE.
- ld_en is ignored while busy = 1.
- start is ignored while busy = 1.
- rst mid-run: in the next cycle, IDLE with the reset values above. No partial word is issued.
- Issue rate with stall low: one instruction every GAP+1 cycles.
- pc increments modulo 2**AW.

Decomposition:
- Shared package: NOP_WORD, HALT_NIBBLE, state enum {IDLE, ISSUE, GAP, DONE}, and the word field slice constants (opcode [14:5], data [4:0]).
- One sub-module, prog_mem: DEPTH x 15 register array with one write port and one combinational read port, no reset.
- FSM, pc and gap counter stay in prog_seq.

Test Plan:
- Load mem[0] = {10'b0001_101_001, 5'd7}, mem[1] = HALT; GAP = 4; pulse start. Required:
  - 1 cycle after start, opcode = 10'b0001_101_001, data = 7.
  - Then 4 NOPs.
  - Then done = 1, busy = 0, pc = 1.
- Fill all 16 words with non-HALT ADDs; GAP = 0. Required: 16 consecutive issues, then done = 1 and pc = 0 (wrap).
- Assert stall for 3 cycles during GAP. Required: the NOP run extends from 4 to 7 cycles; the next instruction is correct; pc is unchanged during the stall.
- Drive ld_en with ld_addr = 0 while busy. Required: memory is unchanged; after rerun the original word reissues.
- Assert rst during the second GAP cycle. Required: next cycle opcode = NOP, pc = 0, busy = 0, done = 0. Pulse start: the program reissues from word 0 with memory intact.
- Pulse start while in DONE. Required: the run restarts and the first word appears again 1 cycle later.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared encodings, word layout and state type for the program sequencer.
package prog_seq_pkg;

  localparam int unsigned WORD_W = 15;
  localparam int unsigned OP_W   = 10;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned OP_LSB = DATA_W;   // opcode occupies [14:5], data [4:0]
  localparam int unsigned CNT_W  = 4;        // gap counter width, GAP range 0..15

  // ADD src 0 -> dst 5; the core demux ignores dst 5, so no register changes
  localparam logic [OP_W-1:0] NOP_WORD    = 10'b0001_000_101;
  localparam logic [3:0]      HALT_NIBBLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A word halts the program when its opcode top nibble is all ones
  function automatic logic is_halt(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 4] == HALT_NIBBLE;
  endfunction

endpackage

// File: rtl/prog_seq_mem.sv
// Program store: register array, one synchronous write port, one combinational read port.
module prog_mem
  import prog_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_seq.sv
// Instruction sequencer: issues program words to the core with NOP bubbles between them.
module prog_seq
  import prog_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned GAP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [WORD_W-1:0] ld_word,
  input  logic              start,
  input  logic              stall,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] data,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] GAP_RELOAD = (GAP == 0) ? CNT_W'(0) : CNT_W'(GAP - 1);
  localparam logic [AW-1:0]    LAST_ADDR  = AW'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [AW-1:0]     pc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OP_W-1:0]   opcode_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              busy_nxt, done_nxt;
  logic              mem_we;
  logic [WORD_W-1:0] rd_word;

  // Host loads are only accepted while not running
  assign mem_we = ld_en && ((state == ST_IDLE) || (state == ST_DONE));

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_word),
    .raddr (pc),
    .rdata (rd_word)
  );

  // State, pc, gap counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      cnt    <= '0;
      opcode <= NOP_WORD;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      opcode <= opcode_nxt;
      data   <= data_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state, next-pc and next-output decode; NOP unless a word is issued
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    cnt_nxt    = cnt;
    opcode_nxt = NOP_WORD;
    data_nxt   = '0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          if (is_halt(rd_word)) begin
            state_nxt = ST_DONE;
          end else begin
            opcode_nxt = rd_word[WORD_W-1:OP_LSB];
            data_nxt   = rd_word[DATA_W-1:0];
            pc_nxt     = pc + AW'(1);
            if (pc == LAST_ADDR) begin
              state_nxt = ST_DONE;
            end else if (GAP == 0) begin
              state_nxt = ST_ISSUE;
            end else begin
              cnt_nxt   = GAP_RELOAD;
              state_nxt = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (!stall) begin
          if (cnt == '0) state_nxt = ST_ISSUE;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_ISSUE) || (state_nxt == ST_GAP);
    done_nxt = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: one instance with GAP=4, one with GAP=0.
module tb_prog_seq;
  import prog_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [3:0]        ld_addr;
  logic [14:0]       ld_word;
  logic              start4, start0;
  logic              stall;
  logic [9:0]        opcode4, opcode0;
  logic [4:0]        data4, data0;
  logic [3:0]        pc4, pc0;
  logic              busy4, busy0, done4, done0;

  int total = 0;
  int bad   = 0;

  logic [14:0] w_a, w_b, w_z, w_halt, w;
  logic [9:0]  nop_op, op_a, op_b;

  always #5 clk = ~clk;

  prog_seq #(.DEPTH(16), .AW(4), .GAP(4)) u_g4 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_word(ld_word),
    .start(start4), .stall(stall), .opcode(opcode4), .data(data4), .pc(pc4),
    .busy(busy4), .done(done4)
  );

  prog_seq #(.DEPTH(16), .AW(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_word(ld_word),
    .start(start0), .stall(1'b0), .opcode(opcode0), .data(data0), .pc(pc0),
    .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [14:0] d);
    ld_en = 1'b1; ld_addr = a; ld_word = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic go4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 40 && !done4; i++) tick();
    chk("wait_done", 32'(done4), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop_op = 10'b0001_000_101;
    op_a   = 10'b0001_101_001;
    op_b   = 10'b0001_010_011;
    w_a    = {op_a, 5'd7};
    w_b    = {op_b, 5'd19};
    w_z    = {10'b0001_111_010, 5'd1};
    w_halt = 15'b1111_000000_00000;

    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_word = '0;
    start4 = 1'b0; start0 = 1'b0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset values
    chk("rst_op",   32'(opcode4), 32'(nop_op));
    chk("rst_data", 32'(data4), 32'd0);
    chk("rst_pc",   32'(pc4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_op0",  32'(opcode0), 32'(nop_op));

    // single word then HALT, GAP=4
    load(4'd0, w_a);
    load(4'd1, w_halt);
    go4();
    chk("t1_busy_issue", 32'(busy4), 32'd1);
    tick();
    chk("t1_op",   32'(opcode4), 32'(op_a));
    chk("t1_data", 32'(data4), 32'd7);
    chk("t1_pc",   32'(pc4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_nop%0d", i), 32'(opcode4), 32'(nop_op));
      chk($sformatf("t1_busy%0d", i), 32'(busy4), 32'd1);
    end
    tick();
    chk("t1_done", 32'(done4), 32'd1);
    chk("t1_busy", 32'(busy4), 32'd0);
    chk("t1_pcend", 32'(pc4), 32'd1);
    chk("t1_opend", 32'(opcode4), 32'(nop_op));

    // restart from DONE
    go4();
    tick();
    chk("t6_op",   32'(opcode4), 32'(op_a));
    chk("t6_data", 32'(data4), 32'd7);
    wait_done4();

    // full memory, GAP=0: 16 back-to-back issues, then pc wraps
    for (int i = 0; i < 16; i++) begin
      w = {4'b0001, 3'(i), 3'(i + 1), 5'(i + 3)};
      load(4'(i), w);
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = {4'b0001, 3'(i), 3'(i + 1), 5'(i + 3)};
      tick();
      chk($sformatf("t2_op%0d", i), 32'(opcode0), 32'(w[14:5]));
      chk($sformatf("t2_data%0d", i), 32'(data0), 32'(w[4:0]));
    end
    chk("t2_done", 32'(done0), 32'd1);
    chk("t2_busy", 32'(busy0), 32'd0);
    chk("t2_pc",   32'(pc0), 32'd0);

    // stall for 3 cycles during GAP stretches the bubble to 7
    load(4'd0, w_a);
    load(4'd1, w_b);
    load(4'd2, w_halt);
    go4();
    tick();
    chk("t3_op_a", 32'(opcode4), 32'(op_a));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_snop%0d", i), 32'(opcode4), 32'(nop_op));
      chk($sformatf("t3_spc%0d", i), 32'(pc4), 32'd1);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_nop%0d", i), 32'(opcode4), 32'(nop_op));
      chk($sformatf("t3_pc%0d", i), 32'(pc4), 32'd1);
    end
    tick();
    chk("t3_op_b",   32'(opcode4), 32'(op_b));
    chk("t3_data_b", 32'(data4), 32'd19);
    chk("t3_pc_b",   32'(pc4), 32'd2);
    wait_done4();

    // load while busy is ignored
    go4();
    tick();
    load(4'd0, w_z);
    wait_done4();
    go4();
    tick();
    chk("t4_op",   32'(opcode4), 32'(op_a));
    chk("t4_data", 32'(data4), 32'd7);
    wait_done4();

    // reset during the second GAP cycle
    go4();
    tick();
    chk("t5_op_a", 32'(opcode4), 32'(op_a));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_op",   32'(opcode4), 32'(nop_op));
    chk("t5_pc",   32'(pc4), 32'd0);
    chk("t5_busy", 32'(busy4), 32'd0);
    chk("t5_done", 32'(done4), 32'd0);
    go4();
    tick();
    chk("t5_reop",   32'(opcode4), 32'(op_a));
    chk("t5_redata", 32'(data4), 32'd7);
    wait_done4();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
